// File: rtl/cache_miss_handler_if.sv
// +----------------------------------------------------------------------+
// | cache_miss_handler_if : request, cache-port and burst-RAM bundle      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface cache_miss_handler_if #(
    parameter int LINE_IX_BITWIDTH = 8
);
    localparam int TAG_BITWIDTH = 28 - LINE_IX_BITWIDTH;

    logic                    req_valid;
    logic [31:0]             req_address;
    logic [TAG_BITWIDTH-1:0] req_victim_tag;
    logic                    req_victim_dirty;
    logic                    busy;
    logic                    done;
    logic [31:0]             cache_address;
    logic [31:0]             cache_data_in;
    logic                    cache_write_enable;
    logic [31:0]             cache_data_out;
    logic                    br_cmd;
    logic                    br_cmd_wr;
    logic [31:0]             br_addr;
    logic [31:0]             br_wr_data;
    logic [31:0]             br_rd_data;
    logic                    br_data_ready;
    logic                    br_busy;

    // Environment side: issues misses, models the cache array and the RAM.
    modport master (
        output req_valid, req_address, req_victim_tag, req_victim_dirty,
        output cache_data_out, br_rd_data, br_data_ready, br_busy,
        input  busy, done, cache_address, cache_data_in, cache_write_enable,
        input  br_cmd, br_cmd_wr, br_addr, br_wr_data
    );

    modport slave (
        input  req_valid, req_address, req_victim_tag, req_victim_dirty,
        input  cache_data_out, br_rd_data, br_data_ready, br_busy,
        output busy, done, cache_address, cache_data_in, cache_write_enable,
        output br_cmd, br_cmd_wr, br_addr, br_wr_data
    );
endinterface

`default_nettype wire

// File: rtl/cache_miss_handler.sv
// +----------------------------------------------------------------------+
// | cache_miss_handler : optional dirty-line write-back, then line fill  |
// | Write-back enabled by macro CACHE_MISS_HANDLER_WRITEBACK_EN. Rev 1.0  |
// +----------------------------------------------------------------------+
`default_nettype none

module cache_miss_handler #(
    parameter int LINE_IX_BITWIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    cache_miss_handler_if.slave bus
);
    localparam int TAG_BITWIDTH = 28 - LINE_IX_BITWIDTH;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
`ifdef CACHE_MISS_HANDLER_WRITEBACK_EN
        WB_READ   = 3'd1,
        WB_CMD    = 3'd2,
        WB_DATA   = 3'd3,
`endif
        FILL_CMD  = 3'd4,
        FILL_DATA = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t                      r_state;
    logic [1:0]                  r_col;
    logic [TAG_BITWIDTH-1:0]     r_req_tag;
    logic [LINE_IX_BITWIDTH-1:0] r_line_ix;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_br_cmd;
    logic                        r_br_cmd_wr;
    logic [31:0]                 r_br_addr;
`ifdef CACHE_MISS_HANDLER_WRITEBACK_EN
    logic [TAG_BITWIDTH-1:0]     r_victim_tag;
    logic [2:0]                  r_rd_cnt;
    logic [31:0]                 r_wb_buf [4];
`endif

    logic [31:0] w_cache_address;
    logic [31:0] w_cache_data_in;
    logic        w_cache_we;
    logic [31:0] w_br_wr_data;
    logic        w_unused;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_col       <= '0;
            r_req_tag   <= '0;
            r_line_ix   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_br_cmd    <= 1'b0;
            r_br_cmd_wr <= 1'b0;
            r_br_addr   <= '0;
`ifdef CACHE_MISS_HANDLER_WRITEBACK_EN
            r_victim_tag <= '0;
            r_rd_cnt     <= '0;
            for (int i = 0; i < 4; i++) r_wb_buf[i] <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_req_tag <= bus.req_address[31 -: TAG_BITWIDTH];
                        r_line_ix <= bus.req_address[LINE_IX_BITWIDTH+3:4];
                        r_busy    <= 1'b1;
                        r_col     <= '0;
`ifdef CACHE_MISS_HANDLER_WRITEBACK_EN
                        r_victim_tag <= bus.req_victim_tag;
                        r_rd_cnt     <= '0;
                        if (bus.req_victim_dirty) begin
                            r_state <= WB_READ;
                        end else
`endif
                        begin
                            r_state     <= FILL_CMD;
                            r_br_cmd    <= 1'b1;
                            r_br_cmd_wr <= 1'b0;
                            r_br_addr   <= {bus.req_address[31:4], 4'b0000};
                        end
                    end
                end
`ifdef CACHE_MISS_HANDLER_WRITEBACK_EN
                // Read data trails the address by one cycle, hence 5 cycles for 4 words.
                WB_READ: begin
                    if (r_rd_cnt != 3'd0) r_wb_buf[r_rd_cnt[1:0] - 2'd1] <= bus.cache_data_out;
                    if (r_rd_cnt == 3'd4) begin
                        r_state     <= WB_CMD;
                        r_br_cmd    <= 1'b1;
                        r_br_cmd_wr <= 1'b1;
                        r_br_addr   <= {r_victim_tag, r_line_ix, 4'b0000};
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 3'd1;
                    end
                end
                WB_CMD: begin
                    if (!bus.br_busy) begin
                        r_br_cmd <= 1'b0;
                        r_col    <= '0;
                        r_state  <= WB_DATA;
                    end
                end
                WB_DATA: begin
                    if (bus.br_data_ready) begin
                        r_col <= r_col + 2'd1;
                        if (r_col == 2'd3) begin
                            r_state     <= FILL_CMD;
                            r_br_cmd    <= 1'b1;
                            r_br_cmd_wr <= 1'b0;
                            r_br_addr   <= {r_req_tag, r_line_ix, 4'b0000};
                        end
                    end
                end
`endif
                FILL_CMD: begin
                    if (!bus.br_busy) begin
                        r_br_cmd <= 1'b0;
                        r_col    <= '0;
                        r_state  <= FILL_DATA;
                    end
                end
                FILL_DATA: begin
                    if (bus.br_data_ready) begin
                        r_col <= r_col + 2'd1;
                        if (r_col == 2'd3) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Fill writes are combinational on br_data_ready; rst_n gating keeps a reset cycle write-free.
    always_comb begin
        w_cache_address = '0;
        w_cache_data_in = '0;
        w_cache_we      = 1'b0;
        w_br_wr_data    = '0;
`ifdef CACHE_MISS_HANDLER_WRITEBACK_EN
        if (r_state == WB_READ && r_rd_cnt != 3'd4)
            w_cache_address = {r_victim_tag, r_line_ix, r_rd_cnt[1:0], 2'b00};
        if (r_state == WB_DATA)
            w_br_wr_data = r_wb_buf[r_col];
`endif
        if (r_state == FILL_DATA) begin
            w_cache_address = {r_req_tag, r_line_ix, r_col, 2'b00};
            if (bus.br_data_ready && rst_n) begin
                w_cache_we      = 1'b1;
                w_cache_data_in = bus.br_rd_data;
            end
        end
    end

`ifdef CACHE_MISS_HANDLER_WRITEBACK_EN
    assign w_unused = ^bus.req_address[3:0];
`else
    assign w_unused = ^{bus.req_address[3:0], bus.req_victim_tag,
                        bus.req_victim_dirty, bus.cache_data_out};
`endif

    assign bus.busy               = r_busy;
    assign bus.done               = r_done;
    assign bus.br_cmd             = r_br_cmd;
    assign bus.br_cmd_wr          = r_br_cmd_wr;
    assign bus.br_addr            = r_br_addr;
    assign bus.br_wr_data         = w_br_wr_data;
    assign bus.cache_address      = w_cache_address;
    assign bus.cache_data_in      = w_cache_data_in;
    assign bus.cache_write_enable = w_cache_we;

endmodule

`default_nettype wire

// File: tb/tb_cache_miss_handler.sv
// +----------------------------------------------------------------------+
// | tb_cache_miss_handler : directed scoreboard bench for the miss FSM   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_cache_miss_handler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_miss_handler_if #(.LINE_IX_BITWIDTH(8)) bus_if ();
    cache_miss_handler #(.LINE_IX_BITWIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    int n_tests = 0;
    int n_fail = 0;
    int cmd_seen = 0;
    int done_seen = 0;
    int wr_beats = 0;
    bit no_wr_check = 1'b0;

    logic [31:0] exp_waddr[$];
    logic [31:0] exp_wdata[$];
    logic [31:0] exp_cmd_addr[$];
    logic        exp_cmd_wr[$];
    logic [31:0] exp_bwdata[$];

    // Cache array model: word value depends on column, one-cycle read latency.
    always @(posedge clk) bus_if.cache_data_out <= 32'h11 + {30'd0, bus_if.cache_address[3:2]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        if (bus_if.cache_write_enable) begin
            if (exp_waddr.size() == 0) begin
                chk("unexpected_cache_write", {31'd0, bus_if.cache_write_enable}, 32'd0);
            end else begin
                chk("cache_wr_addr", bus_if.cache_address, exp_waddr.pop_front());
                chk("cache_wr_data", bus_if.cache_data_in, exp_wdata.pop_front());
            end
        end
        if (bus_if.br_data_ready && wr_beats > 0 && exp_bwdata.size() > 0) begin
            chk("wb_word", bus_if.br_wr_data, exp_bwdata.pop_front());
            wr_beats--;
        end
        if (bus_if.br_cmd && !bus_if.br_busy) begin
            if (exp_cmd_addr.size() == 0) begin
                chk("unexpected_cmd", {31'd0, bus_if.br_cmd}, 32'd0);
            end else begin
                chk("cmd_wr", {31'd0, bus_if.br_cmd_wr}, {31'd0, exp_cmd_wr.pop_front()});
                chk("cmd_addr", bus_if.br_addr, exp_cmd_addr.pop_front());
                if (bus_if.br_cmd_wr) wr_beats = 4;
            end
            cmd_seen++;
        end
        if (no_wr_check) chk("cmd_wr_zero", {31'd0, bus_if.br_cmd_wr}, 32'd0);
        if (bus_if.done) done_seen++;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},   {31'd0, bus_if.busy}, 32'd0);
        chk({tag, "_done"},   {31'd0, bus_if.done}, 32'd0);
        chk({tag, "_brcmd"},  {31'd0, bus_if.br_cmd}, 32'd0);
        chk({tag, "_brwr"},   {31'd0, bus_if.br_cmd_wr}, 32'd0);
        chk({tag, "_we"},     {31'd0, bus_if.cache_write_enable}, 32'd0);
        chk({tag, "_caddr"},  bus_if.cache_address, 32'd0);
        chk({tag, "_cdin"},   bus_if.cache_data_in, 32'd0);
        chk({tag, "_braddr"}, bus_if.br_addr, 32'd0);
        chk({tag, "_brwd"},   bus_if.br_wr_data, 32'd0);
    endtask

    task automatic expect_cmd(input logic wr, input logic [31:0] addr);
        exp_cmd_wr.push_back(wr);
        exp_cmd_addr.push_back(addr);
    endtask

    task automatic expect_fill(input logic [31:0] addr, input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            exp_waddr.push_back({addr[31:4], 4'b0000} + 32'(4 * k));
            exp_wdata.push_back(base + 32'(k));
        end
    endtask

    task automatic req(input logic [31:0] addr, input logic [19:0] vtag, input logic dirty);
        bus_if.req_valid        = 1'b1;
        bus_if.req_address      = addr;
        bus_if.req_victim_tag   = vtag;
        bus_if.req_victim_dirty = dirty;
        step();
        bus_if.req_valid        = 1'b0;
        chk("busy_after_req", {31'd0, bus_if.busy}, 32'd1);
    endtask

    task automatic wait_cmd();
        int start = cmd_seen;
        for (int i = 0; i < 30 && cmd_seen == start; i++) step();
        chk("cmd_timeout", 32'(cmd_seen - start), 32'd1);
    endtask

    task automatic wait_done();
        int start = done_seen;
        for (int i = 0; i < 30 && done_seen == start; i++) step();
        chk("done_timeout", 32'(done_seen - start), 32'd1);
    endtask

    task automatic burst(input logic [31:0] base, input logic [7:0] pat, input int n);
        int k = 0;
        for (int i = 0; i < n; i++) begin
            bus_if.br_data_ready = pat[n-1-i];
            bus_if.br_rd_data    = pat[n-1-i] ? base + 32'(k) : 32'hDEAD_BEEF;
            if (pat[n-1-i]) k++;
            step();
        end
        bus_if.br_data_ready = 1'b0;
    endtask

    initial begin
        int d0;
        int c0;
        bus_if.req_valid        = 1'b0;
        bus_if.req_address      = '0;
        bus_if.req_victim_tag   = '0;
        bus_if.req_victim_dirty = 1'b0;
        bus_if.br_rd_data       = '0;
        bus_if.br_data_ready    = 1'b0;
        bus_if.br_busy          = 1'b0;
        step();
        step();
        chk_idle("reset");
        rst_n = 1'b1;
        step();

        // Clean miss, back-to-back fill words
        expect_cmd(1'b0, 32'h0000_1230);
        expect_fill(32'h0000_1234, 32'hA0, 4);
        d0 = done_seen;
        req(32'h0000_1234, 20'h0, 1'b0);
        wait_cmd();
        burst(32'hA0, 8'b1111, 4);
        wait_done();
        step();
        step();
        chk("done_once", 32'(done_seen - d0), 32'd1);
        chk("busy_cleared", {31'd0, bus_if.busy}, 32'd0);

        // Command held under br_busy; stray req_valid/br_data_ready ignored; gapped fill
        bus_if.br_busy = 1'b1;
        expect_cmd(1'b0, 32'h0000_ABC0);
        expect_fill(32'h0000_ABC0, 32'hB0, 4);
        d0 = done_seen;
        req(32'h0000_ABC0, 20'h0, 1'b0);
        bus_if.req_valid     = 1'b1;
        bus_if.req_address   = 32'h0000_FFF0;
        bus_if.br_data_ready = 1'b1;
        bus_if.br_rd_data    = 32'h55;
        for (int i = 0; i < 3; i++) begin
            chk("hold_brcmd", {31'd0, bus_if.br_cmd}, 32'd1);
            chk("hold_braddr", bus_if.br_addr, 32'h0000_ABC0);
            step();
        end
        bus_if.req_valid     = 1'b0;
        bus_if.br_data_ready = 1'b0;
        bus_if.br_busy       = 1'b0;
        c0 = cmd_seen;
        step();
        chk("accept_4th_cycle", 32'(cmd_seen - c0), 32'd1);
        burst(32'hB0, 8'b0100_1101, 7);
        wait_done();
        step();
        chk("gap_done_once", 32'(done_seen - d0), 32'd1);

        // Reset after the second fill word
        expect_cmd(1'b0, 32'h0000_7770);
        expect_fill(32'h0000_7770, 32'hC0, 2);
        req(32'h0000_7770, 20'h0, 1'b0);
        wait_cmd();
        burst(32'hC0, 8'b11, 2);
        bus_if.br_data_ready = 1'b1;
        bus_if.br_rd_data    = 32'hC2;
        rst_n = 1'b0;
        step();
        chk_idle("midreset");
        rst_n = 1'b1;
        step();
        step();
        bus_if.br_data_ready = 1'b0;
        chk("abandoned_writes_left", 32'(exp_waddr.size()), 32'd0);
        expect_cmd(1'b0, 32'h0000_2040);
        expect_fill(32'h0000_2040, 32'hD0, 4);
        req(32'h0000_2040, 20'h0, 1'b0);
        wait_cmd();
        burst(32'hD0, 8'b1111, 4);
        wait_done();
        step();

`ifdef CACHE_MISS_HANDLER_WRITEBACK_EN
        // Dirty miss: victim line 0x5230 read out and written back before the fill
        expect_cmd(1'b1, 32'h0000_5230);
        for (int k = 0; k < 4; k++) exp_bwdata.push_back(32'h11 + 32'(k));
        expect_cmd(1'b0, 32'h0009_8230);
        expect_fill(32'h0009_8230, 32'hF0, 4);
        req(32'h0009_8230, 20'h5, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("wb_read_addr", bus_if.cache_address, 32'h0000_5230 + 32'(4 * k));
            step();
        end
        wait_cmd();
        burst(32'h0, 8'b1_0111, 5);
        chk("wb_words_left", 32'(exp_bwdata.size()), 32'd0);
        wait_cmd();
        burst(32'hF0, 8'b1111, 4);
        wait_done();
        step();
`else
        // Dirty flag has no effect without write-back support
        no_wr_check = 1'b1;
        expect_cmd(1'b0, 32'h0000_3450);
        expect_fill(32'h0000_3450, 32'hE0, 4);
        req(32'h0000_3450, 20'h5, 1'b1);
        chk("no_wb_brcmd", {31'd0, bus_if.br_cmd}, 32'd1);
        wait_cmd();
        burst(32'hE0, 8'b1111, 4);
        wait_done();
        step();
        no_wr_check = 1'b0;
`endif

        chk("writes_left", 32'(exp_waddr.size()), 32'd0);
        chk("cmds_left", 32'(exp_cmd_addr.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
